// File: rtl/lc3b_types.sv
// Shared types for the hazard/forwarding unit: register id, scoreboard entry,
// forwarding-select constants and the stall FSM state encoding.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic    valid;
    lc3b_reg dr;
    logic    dr_needed;
    logic    is_load;
  } sb_entry_t;

  localparam int FWD_REGFILE = 0;
  localparam int FWD_EXMEM   = 1;
  localparam int FWD_MEMWB   = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FREEZE = 2'd2
  } hfu_state_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage operand bundle presented to the hazard/forwarding unit.
interface hazard_forward_unit_if #(
  parameter int NUM_SRC = 3
) ();
  logic                                  id_valid;
  lc3b_types::lc3b_reg [NUM_SRC-1:0]     id_sr;
  logic                [NUM_SRC-1:0]     id_sr_needed;
  lc3b_types::lc3b_reg                   id_dr;
  logic                                  id_dr_needed;
  logic                                  id_is_load;

  modport master (
    output id_valid, id_sr, id_sr_needed, id_dr, id_dr_needed, id_is_load
  );
  modport slave (
    input  id_valid, id_sr, id_sr_needed, id_dr, id_dr_needed, id_is_load
  );
endinterface

// File: rtl/src_hazard_check.sv
// One source-operand channel: finds the youngest in-flight producer of sr and
// reports the forwarding select it implies and whether it is a load-use hazard.
module src_hazard_check
  import lc3b_types::*;
#(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(STAGES+1)
) (
  input  sb_entry_t [STAGES-1:0] sb,
  input  lc3b_reg                sr,
  input  logic                   sr_needed,
  output logic [SEL_W-1:0]       fwd_nxt,
  output logic                   load_use
);

  // Walk oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    fwd_nxt  = SEL_W'(FWD_REGFILE);
    load_use = 1'b0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (sr_needed && sb[k].valid && sb[k].dr_needed && (sb[k].dr == sr)) begin
        load_use = sb[k].is_load && (k < LOAD_LAT);
        fwd_nxt  = (k + 1 <= STAGES - 1) ? SEL_W'(k + 1) : SEL_W'(FWD_REGFILE);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// LC-3b load-use stall and operand-forwarding control with a producer scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall_count / fwd_count outputs.
module hazard_forward_unit
  import lc3b_types::*;
#(
  parameter  int NUM_SRC  = 3,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(STAGES+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  hazard_forward_unit_if.slave          id,
  input  logic                          pipe_advance,
  input  logic                          flush,
  output logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel,
  output logic                          stall_id,
  output logic [1:0]                    state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]                   stall_count,
  output logic [15:0]                   fwd_count
`endif
);

  sb_entry_t [STAGES-1:0]        sb_q, sb_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] fwd_nxt;
  logic [NUM_SRC-1:0]            load_use;
  hfu_state_e                    state_q, state_d;
  logic                          issue;
  sb_entry_t                     id_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    src_hazard_check #(
      .STAGES  (STAGES),
      .LOAD_LAT(LOAD_LAT),
      .SEL_W   (SEL_W)
    ) u_chk (
      .sb       (sb_q),
      .sr       (id.id_sr[i]),
      .sr_needed(id.id_sr_needed[i]),
      .fwd_nxt  (fwd_nxt[i]),
      .load_use (load_use[i])
    );
  end

  // Flush wins over stall: a squashed ID instruction never holds the front end.
  assign stall_id = id.id_valid & ~flush & (|load_use);
  assign issue    = id.id_valid & ~stall_id & ~flush;

  always_comb begin
    id_entry.valid     = 1'b1;
    id_entry.dr        = id.id_dr;
    id_entry.dr_needed = id.id_dr_needed;
    id_entry.is_load   = id.id_is_load;
  end

  always_comb begin
    sb_d      = sb_q;
    fwd_sel_d = fwd_sel_q;
    if (pipe_advance) begin
      for (int k = STAGES-1; k > 0; k--) sb_d[k] = sb_q[k-1];
      sb_d[0]   = issue ? id_entry : '0;
      fwd_sel_d = issue ? fwd_nxt : '0;
    end else if (flush) begin
      // Frozen pipe: only the EX occupant is squashed, older stages hold.
      sb_d[0].valid = 1'b0;
      fwd_sel_d     = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!pipe_advance)  state_d = ST_FREEZE;
    else if (stall_id)  state_d = ST_LSTALL;
    else                state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q      <= '0;
      fwd_sel_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      sb_q      <= sb_d;
      fwd_sel_q <= fwd_sel_d;
      state_q   <= state_d;
    end
  end

  assign fwd_sel = fwd_sel_q;
  assign state   = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] fwd_count_q, fwd_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (pipe_advance && stall_id && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
    if (pipe_advance && (|fwd_sel_d) && (fwd_count_q != 16'hFFFF))
      fwd_count_d = fwd_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus a
// randomized run against an in-bench pipeline-occupancy model.
module tb_hazard_forward_unit;
  import lc3b_types::*;

  localparam int NS = 3;
  localparam int ST = 3;
  localparam int LL = 1;
  localparam int SW = $clog2(ST+1);

  logic                    clk = 1'b0;
  logic                    rst, pipe_advance, flush;
  logic [NS-1:0][SW-1:0]   fwd_sel;
  logic                    stall_id;
  logic [1:0]              state;
`ifdef HAZARD_PERF_EN
  logic [15:0]             stall_count, fwd_count;
`endif

  hazard_forward_unit_if #(.NUM_SRC(NS)) ifc ();

  hazard_forward_unit #(.NUM_SRC(NS), .STAGES(ST), .LOAD_LAT(LL)) dut (
    .clk         (clk),
    .rst         (rst),
    .id          (ifc.slave),
    .pipe_advance(pipe_advance),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall_id    (stall_id),
    .state       (state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (stall_count),
    .fwd_count   (fwd_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: what instruction occupies each producer stage (0 = EX), as plain ints.
  int   occ_valid [ST];
  int   occ_dr    [ST];
  int   occ_wr    [ST];
  int   occ_load  [ST];
  int   mf        [NS];
  logic [1:0] mst;
  bit   exp_stall;
  int   exp_nf    [NS];
  logic obs_stall;

  function automatic void model_eval();
    exp_stall = 1'b0;
    for (int c = 0; c < NS; c++) begin
      exp_nf[c] = 0;
      if (ifc.id_sr_needed[c]) begin
        // distance d = stages ahead of ID; producer value sits in latch d unless retired
        for (int d = 1; d <= ST; d++) begin
          if (occ_valid[d-1] != 0 && occ_wr[d-1] != 0 && occ_dr[d-1] == int'(ifc.id_sr[c])) begin
            if (occ_load[d-1] != 0 && (d - 1) < LL) exp_stall = 1'b1;
            exp_nf[c] = (d < ST) ? d : 0;
            break;
          end
        end
      end
    end
    if (!ifc.id_valid || flush) exp_stall = 1'b0;
  endfunction

  task automatic tick();
    bit enter;
    @(negedge clk);
    model_eval();
    obs_stall = stall_id;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < ST; k++) occ_valid[k] = 0;
      for (int c = 0; c < NS; c++) mf[c] = 0;
      mst = ST_RUN;
    end else begin
      if (pipe_advance) begin
        for (int k = ST-1; k > 0; k--) begin
          occ_valid[k] = occ_valid[k-1]; occ_dr[k] = occ_dr[k-1];
          occ_wr[k] = occ_wr[k-1]; occ_load[k] = occ_load[k-1];
        end
        enter = ifc.id_valid && !exp_stall && !flush;
        occ_valid[0] = int'(enter);
        occ_dr[0]    = int'(ifc.id_dr);
        occ_wr[0]    = int'(ifc.id_dr_needed);
        occ_load[0]  = int'(ifc.id_is_load);
        for (int c = 0; c < NS; c++) mf[c] = enter ? exp_nf[c] : 0;
      end else if (flush) begin
        occ_valid[0] = 0;
        for (int c = 0; c < NS; c++) mf[c] = 0;
      end
      mst = !pipe_advance ? ST_FREEZE : (exp_stall ? ST_LSTALL : ST_RUN);
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int s0, input int s1, input int s2,
                        input bit [2:0] need, input int dr, input bit wr, input bit ld);
    ifc.id_valid     = v;
    ifc.id_sr[0]     = lc3b_reg'(s0);
    ifc.id_sr[1]     = lc3b_reg'(s1);
    ifc.id_sr[2]     = lc3b_reg'(s2);
    ifc.id_sr_needed = need;
    ifc.id_dr        = lc3b_reg'(dr);
    ifc.id_dr_needed = wr;
    ifc.id_is_load   = ld;
  endtask

  task automatic do_reset();
    rst = 1'b1; pipe_advance = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 3'b000, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (fwd_sel !== '0) begin tests_failed++; $display("FAIL reset_fwd got=%h want=0", fwd_sel); end
    tests_run++; if (state !== ST_RUN) begin tests_failed++; $display("FAIL reset_state got=%0d want=%0d", state, ST_RUN); end
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b want=0", stall_id); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_id(1, 2, 3, 0, 3'b011, 1, 1, 0);    // ADD R1,R2,R3
    tick();
    set_id(1, 1, 3, 0, 3'b011, 2, 1, 0);    // ADD R2,R1,R3
    tick();
    tests_run++; if (obs_stall !== 1'b0) begin tests_failed++; $display("FAIL alu_stall got=%b want=0", obs_stall); end
    tests_run++; if (fwd_sel[0] !== SW'(1)) begin tests_failed++; $display("FAIL alu_fwd0 got=%0d want=1", fwd_sel[0]); end
    tests_run++; if (fwd_sel[1] !== SW'(0)) begin tests_failed++; $display("FAIL alu_fwd1 got=%0d want=0", fwd_sel[1]); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 6, 0, 0, 3'b001, 4, 1, 1);    // LDR R4,R6
    tick();
    set_id(1, 4, 4, 0, 3'b011, 5, 1, 0);    // ADD R5,R4,R4
    tick();
    tests_run++; if (obs_stall !== 1'b1) begin tests_failed++; $display("FAIL lu_stall got=%b want=1", obs_stall); end
    tests_run++; if (fwd_sel !== '0) begin tests_failed++; $display("FAIL lu_bubble_fwd got=%h want=0", fwd_sel); end
    tests_run++; if (state !== ST_LSTALL) begin tests_failed++; $display("FAIL lu_state got=%0d want=%0d", state, ST_LSTALL); end
    tick();
    tests_run++; if (obs_stall !== 1'b0) begin tests_failed++; $display("FAIL lu_release got=%b want=0", obs_stall); end
    tests_run++; if (fwd_sel[0] !== SW'(2) || fwd_sel[1] !== SW'(2)) begin
      tests_failed++; $display("FAIL lu_fwd got=%0d,%0d want=2,2", fwd_sel[0], fwd_sel[1]); end
    tests_run++; if (state !== ST_RUN) begin tests_failed++; $display("FAIL lu_state_run got=%0d want=%0d", state, ST_RUN); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1, 0, 0, 0, 3'b000, 6, 1, 0);    // producer of R6
    tick();
    set_id(1, 6, 0, 0, 3'b001, 4, 1, 1);    // LDR R4,R6
    tick();
    tests_run++; if (fwd_sel[0] !== SW'(1)) begin tests_failed++; $display("FAIL frz_pre_fwd got=%0d want=1", fwd_sel[0]); end
    set_id(1, 4, 4, 0, 3'b011, 5, 1, 0);
    pipe_advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (obs_stall !== 1'b1 || state !== ST_FREEZE || fwd_sel[0] !== SW'(1)) begin
        tests_failed++; $display("FAIL frz_hold cyc=%0d got stall=%b state=%0d fwd0=%0d want 1,%0d,1", i, obs_stall, state, fwd_sel[0], ST_FREEZE); end
    end
    pipe_advance = 1'b1;
    tick();
    tests_run++; if (obs_stall !== 1'b1 || fwd_sel !== '0) begin
      tests_failed++; $display("FAIL frz_bubble got stall=%b fwd=%h want 1,0", obs_stall, fwd_sel); end
    tick();
    tests_run++; if (obs_stall !== 1'b0 || fwd_sel[0] !== SW'(2) || fwd_sel[1] !== SW'(2)) begin
      tests_failed++; $display("FAIL frz_after got stall=%b fwd=%0d,%0d want 0,2,2", obs_stall, fwd_sel[0], fwd_sel[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 0, 0, 0, 3'b000, 4, 1, 1);    // LDR R4
    tick();
    set_id(1, 4, 4, 0, 3'b011, 5, 1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++; if (obs_stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall got=%b want=0", obs_stall); end
    tests_run++; if (fwd_sel !== '0) begin tests_failed++; $display("FAIL flush_fwd got=%h want=0", fwd_sel); end
    set_id(1, 5, 4, 0, 3'b011, 7, 1, 0);    // reads squashed R5 and the load's R4
    tick();
    tests_run++; if (fwd_sel[0] !== SW'(0) || fwd_sel[1] !== SW'(2)) begin
      tests_failed++; $display("FAIL flush_entry0 got=%0d,%0d want=0,2", fwd_sel[0], fwd_sel[1]); end
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    set_id(1, 0, 0, 0, 3'b000, 4, 1, 1);
    tick();
    set_id(1, 4, 0, 0, 3'b001, 5, 1, 0);
    tick();
    tests_run++; if (state !== ST_LSTALL) begin tests_failed++; $display("FAIL rms_pre got=%0d want=%0d", state, ST_LSTALL); end
    rst = 1'b1; flush = 1'b1; pipe_advance = 1'b0;
    tick();
    rst = 1'b0; flush = 1'b0; pipe_advance = 1'b1;
    #1;
    tests_run++; if (state !== ST_RUN || stall_id !== 1'b0 || fwd_sel !== '0) begin
      tests_failed++; $display("FAIL rms_after got state=%0d stall=%b fwd=%h want %0d,0,0", state, stall_id, fwd_sel, ST_RUN); end
  endtask

  task automatic test_unused_operand();
    do_reset();
    set_id(1, 0, 0, 0, 3'b000, 1, 1, 1);    // LDR R1
    tick();
    set_id(1, 1, 1, 1, 3'b000, 2, 1, 0);    // ADD R2,R1,#imm with sr not read
    tick();
    tests_run++; if (obs_stall !== 1'b0 || fwd_sel !== '0) begin
      tests_failed++; $display("FAIL imm got stall=%b fwd=%h want 0,0", obs_stall, fwd_sel); end
    set_id(1, 0, 0, 0, 3'b000, 3, 0, 0);    // R3 named but not written
    tick();
    set_id(1, 3, 2, 0, 3'b011, 6, 1, 0);
    tick();
    tests_run++; if (fwd_sel[0] !== SW'(0) || fwd_sel[1] !== SW'(2)) begin
      tests_failed++; $display("FAIL nowr got=%0d,%0d want=0,2", fwd_sel[0], fwd_sel[1]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      pipe_advance = ($urandom_range(0, 3) != 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
             $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
      tick();
      tests_run++; if (obs_stall !== exp_stall) begin
        tests_failed++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, obs_stall, exp_stall); end
      for (int c = 0; c < NS; c++) begin
        tests_run++; if (fwd_sel[c] !== SW'(mf[c])) begin
          tests_failed++; $display("FAIL rnd_fwd n=%0d ch=%0d got=%0d want=%0d", n, c, fwd_sel[c], mf[c]); end
      end
      tests_run++; if (state !== mst) begin
        tests_failed++; $display("FAIL rnd_state n=%0d got=%0d want=%0d", n, state, mst); end
    end
    rst = 1'b0; flush = 1'b0; pipe_advance = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < ST; k++) begin occ_valid[k] = 0; occ_dr[k] = 0; occ_wr[k] = 0; occ_load[k] = 0; end
    for (int c = 0; c < NS; c++) mf[c] = 0;
    mst = ST_RUN;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_freeze();
    test_flush();
    test_rst_mid_stall();
    test_unused_operand();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
